// File: rtl/int_to_fp_serial_pkg.sv
// Shared types and constants for the integer-to-float front end and the adder-side blocks.
// The float is value = (-1)^sign * frac * 2^(exp-8), with an explicit leading fraction bit.
package int_to_fp_serial_pkg;

    localparam int INT_W    = 8;
    localparam int EXP_W    = 4;
    localparam int FRAC_W   = 8;
    localparam int EXP_INIT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/int_to_fp_serial_sign_mag.sv
// Combinational split of a two's-complement integer into sign and unsigned magnitude.
// The most negative value maps to its own bit pattern (e.g. -128 -> 0x80).
module int_sign_mag #(
    parameter int W = 8
) (
    input  logic [W-1:0] int_in,
    output logic         sign,
    output logic [W-1:0] mag
);

    assign sign = int_in[W-1];
    assign mag  = sign ? (W'(0) - int_in) : int_in;

endmodule

// File: rtl/int_to_fp_serial.sv
// Serial integer-to-float converter: captures a signed integer, then normalizes the
// magnitude one bit per cycle until the fraction MSB is set, and presents the result.
module int_to_fp_serial
    import int_to_fp_serial_pkg::*;
#(
    parameter int INT_W  = 8,
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INT_W-1:0]  int_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              busy,
    output state_t            dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE, out_valid only in DONE, and neither side may
    // withdraw valid or change data until that edge.

    localparam logic [EXP_W-1:0] EXP_START = EXP_W'(EXP_INIT);

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic                in_sign;
    logic [INT_W-1:0]    in_mag;

    int_sign_mag #(.W(INT_W)) u_sign_mag (
        .int_in (int_in),
        .sign   (in_sign),
        .mag    (in_mag)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            frac_q  <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            frac_q  <= frac_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_mag == '0) begin
                        // Zero skips normalization entirely and is reported as all-zero.
                        state_d = DONE;
                        sign_d  = 1'b0;
                        exp_d   = '0;
                        frac_d  = '0;
                    end else begin
                        state_d = NORM;
                        sign_d  = in_sign;
                        exp_d   = EXP_START;
                        frac_d  = FRAC_W'(in_mag);
                    end
                end
            end
            NORM: begin
                // A nonzero magnitude reaches frac[7]=1 with exp >= 1, so no underflow.
                if (frac_q[FRAC_W-1]) begin
                    state_d = DONE;
                end else begin
                    frac_d = frac_q << 1;
                    exp_d  = exp_q - EXP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sign_out  = sign_q;
    assign exp_out   = exp_q;
    assign frac_out  = frac_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_int_to_fp_serial.sv
// Directed bench for int_to_fp_serial: reset, latency/format vectors, output hold,
// mid-conversion reset and a back-to-back sweep of all 256 inputs.
module tb_int_to_fp_serial;
    import int_to_fp_serial_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  int_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [3:0]  exp_out;
    logic [7:0]  frac_out;
    logic        busy;
    state_t      dbg_state;

    int total;
    int bad;
    logic [12:0] exp_q[$];

    int_to_fp_serial dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .int_in    (int_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .frac_out  (frac_out),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference conversion: {sign, exp[3:0], frac[7:0]}.
    function automatic logic [12:0] model(input logic [7:0] v);
        logic       s;
        logic [7:0] m;
        logic [3:0] e;
        s = v[7];
        m = s ? (8'd0 - v) : v;
        if (m == 8'd0) return 13'd0;
        e = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (!m[7]) begin
                m = m << 1;
                e = e - 4'd1;
            end
        end
        return {s, e, m};
    endfunction

    // Driver: call #1 after a rising edge; returns cycles from capture edge to out_valid.
    task automatic send(input logic [7:0] v, output int lat, output bit ok);
        int n;
        ok  = 1'b1;
        lat = 0;
        n   = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            ok = 1'b0;
            return;
        end
        in_valid = 1'b1;
        int_in   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) ok = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        int_in    = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, busy, sign_out, exp_out, frac_out} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%0b busy=%0b s=%0b e=%0h f=%0h, want all 0",
                     out_valid, busy, sign_out, exp_out, frac_out);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || dbg_state !== IDLE) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%0b state=%0d, want 1/IDLE", in_ready, dbg_state);
        end
    endtask

    task automatic test_vectors();
        logic [7:0]  vec_in  [4] = '{8'h05, 8'h80, 8'h00, 8'hFF};
        int          vec_lat [4] = '{6, 1, 0, 8};
        logic [12:0] vec_res [4] = '{{1'b0, 4'd3, 8'hA0}, {1'b1, 4'd8, 8'h80},
                                     13'd0, {1'b1, 4'd1, 8'h80}};
        int lat;
        bit ok;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(vec_in[i], lat, ok);
            total++;
            if (!ok || lat != vec_lat[i]) begin
                bad++;
                $display("FAIL latency_%02h: got ok=%0b lat=%0d, want lat=%0d", vec_in[i], ok, lat, vec_lat[i]);
            end
            total++;
            if ({sign_out, exp_out, frac_out} !== vec_res[i]) begin
                bad++;
                $display("FAIL result_%02h: got s=%0b e=%0d f=%02h, want %04h", vec_in[i],
                         sign_out, exp_out, frac_out, vec_res[i]);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL release_%02h: got out_valid=%0b in_ready=%0b, want 0/1", vec_in[i], out_valid, in_ready);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        bit ok;
        out_ready = 1'b0;
        send(8'h7F, lat, ok);
        total++;
        if (!ok || lat != 2) begin
            bad++;
            $display("FAIL hold_latency: got ok=%0b lat=%0d, want 2", ok, lat);
        end
        // A new input offered while DONE must be ignored.
        in_valid = 1'b1;
        int_in   = 8'h33;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if ({sign_out, exp_out, frac_out} !== {1'b0, 4'd7, 8'hFE} || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: got s=%0b e=%0d f=%02h ov=%0b ir=%0b, want 0/7/FE ov=1 ir=0",
                         c, sign_out, exp_out, frac_out, out_valid, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (dbg_state !== IDLE || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: got state=%0d ov=%0b ir=%0b busy=%0b, want IDLE/0/1/0",
                     dbg_state, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        int_in    = 8'h01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dbg_state !== NORM) begin
            bad++;
            $display("FAIL mid_state: got state=%0d, want NORM", dbg_state);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, sign_out, exp_out, frac_out} !== 15'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_outputs: got ov=%0b busy=%0b s=%0b e=%0h f=%0h ir=%0b, want zeros ir=1",
                     out_valid, busy, sign_out, exp_out, frac_out, in_ready);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_release: got in_ready=%0b, want 1", in_ready);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_stale: got %0d out_valid cycles, want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int          idx;
        int          results;
        int          cyc;
        bit          pending;
        logic [12:0] want;
        idx       = 0;
        results   = 0;
        cyc       = 0;
        pending   = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        while ((idx < 256 || exp_q.size() != 0) && cyc < 4000) begin
            if (pending) begin
                idx++;
                pending = 1'b0;
            end
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra: unexpected result s=%0b e=%0d f=%02h", sign_out, exp_out, frac_out);
                end else begin
                    want = exp_q.pop_front();
                    results++;
                    if ({sign_out, exp_out, frac_out} !== want) begin
                        bad++;
                        $display("FAIL b2b_result%0d: got %04h, want %04h", results - 1,
                                 {sign_out, exp_out, frac_out}, want);
                    end
                end
            end
            if (idx < 256) begin
                in_valid = 1'b1;
                int_in   = 8'(idx);
                if (in_ready) begin
                    exp_q.push_back(model(8'(idx)));
                    pending = 1'b1;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (results != 256 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count: got %0d results, %0d pending, want 256/0", results, exp_q.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_vectors();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_to_fp_serial.md
INT_TO_FP_SERIAL -- requirements
Module: int_to_fp_serial

Interface
REQ-001 The module SHALL have parameter INT_W, default 8, meaning signed two's-complement integer input width; only 8 is supported.
REQ-002 The module SHALL have parameter EXP_W, default 4, meaning exponent width of the packed float.
REQ-003 The module SHALL have parameter FRAC_W, default 8, meaning fraction width of the packed float; the MSB is explicit, not hidden.
REQ-004 The module SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset_n  input  1  meaning reset; it is asynchronous and active-low.
REQ-006 The module SHALL have port in_valid  input  1  meaning int_in is valid this cycle.
REQ-007 The module SHALL have port in_ready  output  1  meaning the block accepts int_in this cycle.
REQ-008 The module SHALL have port int_in  input  8  meaning the signed integer to convert.
REQ-009 The module SHALL have port out_valid  output  1  meaning sign_out, exp_out and frac_out hold a result.
REQ-010 The module SHALL have port out_ready  input  1  meaning the downstream adder operand register takes the result.
REQ-011 The module SHALL have port sign_out  output  1  meaning the result sign.
REQ-012 The module SHALL have port exp_out  output  4  meaning the result exponent.
REQ-013 The module SHALL have port frac_out  output  8  meaning the normalized result fraction.
REQ-014 The module SHALL have port busy  output  1  meaning the state is not IDLE.

Function
REQ-015 Number format SHALL be value = (-1)^sign * frac * 2^(exp-8); normalized means frac[7]=1; zero SHALL be sign=0, exp=0, frac=0.
REQ-016 FSM SHALL have states IDLE, NORM and DONE; in_ready SHALL equal (state==IDLE).
REQ-017 In IDLE with in_valid=1, the block SHALL capture sign=int_in[7] and mag=|int_in| as 8-bit unsigned (-128 -> 0x80), load exp=8 and frac=mag.
REQ-018 On that capture, the next state SHALL be DONE with sign=0, exp=0, frac=0 if mag==0; otherwise the next state SHALL be NORM.
REQ-019 NORM SHALL check one bit per cycle: if frac[7]=1 the next state SHALL be DONE; else frac<=frac<<1 and exp<=exp-1, staying in NORM.
REQ-020 Latency SHALL be, with L = leading zeros of mag and capture at edge E0: out_valid rises after edge E0+L+1 for mag!=0, and after E0 for mag==0.
REQ-021 Exponent underflow SHALL be impossible, since minimum exp = 1 for mag=1; exp arithmetic SHALL be 4-bit unsigned.
REQ-022 In DONE, out_valid SHALL be 1; sign_out, exp_out and frac_out SHALL be registered and held stable while out_ready=0.
REQ-023 In DONE with out_ready=1, the next state SHALL be IDLE; a new input SHALL NOT be accepted in that same cycle, leaving a minimum one-cycle bubble.
REQ-024 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-025 Outputs SHALL drive directly into one operand of the downstream floating-point adder, with no further normalization needed.

Reset
REQ-026 While reset_n=0, the block SHALL asynchronously force state=IDLE, out_valid=0, busy=0, sign_out=0, exp_out=0 and frac_out=0.
REQ-027 Reset asserted mid-conversion SHALL abandon the in-flight operand, and no result SHALL be emitted.
REQ-028 After reset_n deasserts, in_ready SHALL be 1 on the first clock.

Structure
REQ-029 A shared package SHALL hold the state type (IDLE/NORM/DONE) and constants INT_W=8, EXP_W=4, FRAC_W=8 and EXP_INIT=8, reused by the adder-side blocks.
REQ-030 One sub-module, int_sign_mag, SHALL be combinational and map int_in to the sign bit and 8-bit magnitude.
REQ-031 All other logic SHALL be in a single clocked process plus next-state logic, with no latches.

Verification
REQ-032 The bench SHALL cover: int_in=0x05 -> after 6 cycles of NORM, out_valid=1 with sign=0, exp=3, frac=0xA0.
REQ-033 The bench SHALL cover: int_in=0x80 (-128) -> sign=1, exp=8, frac=0x80; out_valid after E0+1.
REQ-034 The bench SHALL cover: int_in=0x00 -> out_valid after E0 with sign=0, exp=0, frac=0; int_in=0xFF (-1) -> sign=1, exp=1, frac=0x80 after E0+8.
REQ-035 The bench SHALL cover: result 0x7F held with out_ready=0 for 5 cycles -> outputs stable (sign=0, exp=7, frac=0xFE) and in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-036 The bench SHALL cover: reset_n pulsed low during NORM for 0x01 -> out_valid stays 0, all outputs 0, in_ready=1 after release, and no stale result appears.
REQ-037 The bench SHALL cover: back-to-back in_valid with out_ready tied 1 -> each input is accepted only when in_ready=1, and a golden-model comparison passes for all 256 int_in values.
